key_action_decoder: RTL
=======================

# key_action_decoder

Converts the raw 11-bit PS/2 key-event stream from `keyboard` into registered one-cycle action pulses for the game top: two players' W/A/S/D-equivalents, pause, start, reset and boom. It performs its own make/break tracking and generates delayed auto-repeat (DAS/ARR) for the held movement keys. It sits between `keyboard` and the top-level control FSM / `player` instances.

## Interface
- `DAS_CYCLES`, default 20_000_000 (200 ms at 100 MHz); delay from first pulse to first auto-repeat pulse; must be ≥ 2.
- `ARR_CYCLES`, default 5_000_000 (50 ms); period between auto-repeat pulses; must be ≥ 2.
- `clk`  in  1  system clock (100 MHz domain, same as `keyboard`).
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `key_event`  in  11  [10] valid strobe (one cycle per event), [9] E0 extended prefix, [8] break (release), [7:0] scan code.
- `w1, a1, s1, d1`  out  1 each  player-1 rotate/left/down/right pulses.
- `w2, a2, s2, d2`  out  1 each  player-2 pulses (arrow keys).
- `pause, space, rst_req, boom1, boom2`  out  1 each  P, Space, R, key `1` (0x16), keypad `1` (0x69) pulses.
- `held`  out  8  live held state {d2,s2,a2,w2,d1,s1,a1,w1}.

## Operation
- Key map, non-extended (E0=0): 0x1D W, 0x1C A, 0x1B S, 0x23 D, 0x4D P, 0x29 Space, 0x2D R, 0x16 boom1, 0x69 boom2. Extended (E0=1): 0x75 up→w2, 0x6B left→a2, 0x72 down→s2, 0x74 right→d2. Any code with the wrong E0 value, or unmapped, is ignored.
- Make event (valid=1, break=0) for a key whose `held` bit is 0: set `held`, emit its pulse. Make for an already-held key (PS/2 typematic) is ignored.
- Break event: clear `held`, return its repeat FSM to IDLE, emit nothing. Break for a non-held key: no effect.
- Non-directional keys (P, Space, R, boom1, boom2) have no held state: every make, including typematic repeats, pulses once.
- Rotate keys (w1, w2): pulse on first make only, no auto-repeat.
- Repeating keys (a1, s1, d1, a2, s2, d2): each has an independent FSM plus counter sized `$clog2(max(DAS_CYCLES,ARR_CYCLES))`.
  - IDLE → DELAY on accepted make; counter cleared.
  - DELAY: count; at DAS_CYCLES elapsed, pulse, → REPEAT, counter cleared.
  - REPEAT: count; every ARR_CYCLES, pulse; counter wraps to 0.
  - DELAY/REPEAT → IDLE on break; counter cleared.
- Keys are independent; opposite directions held together both repeat.
- At most one key_event is accepted per cycle; no queuing needed.

## Timing
- All outputs registered; reset value of every output and of `held` is 0; all FSMs IDLE, counters 0.
- Make accepted at edge t → pulse high for exactly the cycle after edge t (t+1), low otherwise.
- Auto-repeat pulses at t+1+DAS_CYCLES, then every ARR_CYCLES after that.
- Break at edge b: no pulse from that key at cycle b+1 or later, even if one was scheduled for b+1.
- Make and a scheduled repeat of a different key in the same cycle: both pulse.
- `held` updates in the cycle after the event, same as pulses.
- `rst` asserted mid-repeat: outputs drop to 0 immediately (asynchronous); after release no pulse until a new make.

## Test plan
- Reset: assert `rst` with random key_event → all outputs 0, `held`=0; release, idle 100 cycles → no pulses.
- Single tap (DAS=10, ARR=4): make 0x1C, break after 5 cycles → a1 pulses once at t+1, `held[1]` high for 5 cycles, no further pulses.
- Hold/repeat (DAS=10, ARR=4): make E0 0x6B at t, hold 30 cycles → a2 pulses at t+1, t+11, t+15, t+19, t+23, t+27; break → nothing further.
- Filtering: 0x75 without E0 and 0x1D with E0 → no pulses, `held` unchanged; typematic 0x23 makes every 3 cycles while held → single d1 pulse plus DAS/ARR schedule only.
- One-shots: make 0x4D three times (typematic) → three `pause` pulses; 0x29, 0x2D, 0x16, 0x69 each give one `space`, `rst_req`, `boom1`, `boom2` pulse.
- Boundary: break at edge where next repeat was due → no pulse; `rst` asserted mid-REPEAT of s1 → s1 and `held` drop to 0 at once; after release, s1 stays 0 until a new make.

Source files
------------

// File: rtl/key_action_decoder.sv
// -----------------------------------------------------------------------------
// key_action_decoder
//
// Turns the PS/2 key-event stream from `keyboard` into registered one-cycle
// action pulses for the game top. Movement keys keep a held state and, except
// for the two rotate keys, auto-repeat after DAS_CYCLES and then every
// ARR_CYCLES while held. Non-directional keys pulse once per make event,
// including PS/2 typematic repeats.
//
// Parameters
//   DAS_CYCLES  delay from the first pulse to the first auto-repeat (>= 2)
//   ARR_CYCLES  period between auto-repeat pulses (>= 2)
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   key_event  [10] valid strobe, [9] E0 prefix, [8] break, [7:0] scan code
//   w1..d1     player-1 rotate/left/down/right pulses
//   w2..d2     player-2 pulses (arrow keys)
//   pause, space, rst_req, boom1, boom2   one-shot pulses
//   held       live held state {d2,s2,a2,w2,d1,s1,a1,w1}
// -----------------------------------------------------------------------------
module key_action_decoder #(
  parameter int DAS_CYCLES = 20_000_000,
  parameter int ARR_CYCLES = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] key_event,
  output logic        w1,
  output logic        a1,
  output logic        s1,
  output logic        d1,
  output logic        w2,
  output logic        a2,
  output logic        s2,
  output logic        d2,
  output logic        pause,
  output logic        space,
  output logic        rst_req,
  output logic        boom1,
  output logic        boom2,
  output logic [7:0]  held
);

  localparam int MAX_CYCLES = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);

  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_CYCLES - 1);

  // Movement key index order matches `held`: {d2,s2,a2,w2,d1,s1,a1,w1}.
  // Rotate keys (bits 0 and 4) never leave IDLE, so they never repeat.
  localparam logic [7:0] REPEAT_MASK = 8'b1110_1110;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_DELAY,
    RS_REPEAT
  } rep_state_t;

  // One-shot index order: pause, space, rst_req, boom1, boom2.
  localparam int SHOT_N = 5;

  logic             ev_valid;
  logic             ev_e0;
  logic             ev_brk;
  logic [7:0]       ev_code;
  logic [7:0]       hit_move;
  logic [SHOT_N-1:0] hit_shot;

  rep_state_t       rstate [8];
  logic [CNT_W-1:0] cnt    [8];
  logic [7:0]       held_q;
  logic [7:0]       move_q;
  logic [SHOT_N-1:0] shot_q;

  assign ev_valid = key_event[10];
  assign ev_e0    = key_event[9];
  assign ev_brk   = key_event[8];
  assign ev_code  = key_event[7:0];

  // Scan-code decode. A code seen with the wrong E0 value decodes to nothing.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    hit_move = '0;
    hit_shot = '0;
    if (ev_valid) begin
      if (!ev_e0) begin
        case (ev_code)
          8'h1D:   hit_move[0] = 1'b1;
          8'h1C:   hit_move[1] = 1'b1;
          8'h1B:   hit_move[2] = 1'b1;
          8'h23:   hit_move[3] = 1'b1;
          8'h4D:   hit_shot[0] = 1'b1;
          8'h29:   hit_shot[1] = 1'b1;
          8'h2D:   hit_shot[2] = 1'b1;
          8'h16:   hit_shot[3] = 1'b1;
          8'h69:   hit_shot[4] = 1'b1;
          default: ;
        endcase
      end else begin
        case (ev_code)
          8'h75:   hit_move[4] = 1'b1;
          8'h6B:   hit_move[5] = 1'b1;
          8'h72:   hit_move[6] = 1'b1;
          8'h74:   hit_move[7] = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // NOTE: the per-key FSM state and counters are few and small, so they are
  // reset like any other flop; nothing here is a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q <= '0;
      move_q <= '0;
      shot_q <= '0;
      for (int i = 0; i < 8; i++) begin
        rstate[i] <= RS_IDLE;
        cnt[i]    <= '0;
      end
    end else begin
      // NOTE: state is updated with non-blocking assignments so every key sees
      // the pre-edge values regardless of loop order.
      shot_q <= (ev_valid && !ev_brk) ? hit_shot : '0;

      for (int i = 0; i < 8; i++) begin
        move_q[i] <= 1'b0;
        if (hit_move[i] && ev_brk) begin
          // Release wins over any repeat due at this edge.
          held_q[i] <= 1'b0;
          rstate[i] <= RS_IDLE;
          cnt[i]    <= '0;
        end else if (hit_move[i] && !held_q[i]) begin
          held_q[i] <= 1'b1;
          move_q[i] <= 1'b1;
          rstate[i] <= REPEAT_MASK[i] ? RS_DELAY : RS_IDLE;
          cnt[i]    <= '0;
        end else begin
          // Typematic makes of a held key fall through here and do not
          // disturb the running DAS/ARR schedule.
          case (rstate[i])
            RS_DELAY: begin
              if (cnt[i] == DAS_LAST) begin
                move_q[i] <= 1'b1;
                rstate[i] <= RS_REPEAT;
                cnt[i]    <= '0;
              end else begin
                cnt[i] <= cnt[i] + 1'b1;
              end
            end
            RS_REPEAT: begin
              if (cnt[i] == ARR_LAST) begin
                move_q[i] <= 1'b1;
                cnt[i]    <= '0;
              end else begin
                cnt[i] <= cnt[i] + 1'b1;
              end
            end
            default: cnt[i] <= '0;
          endcase
        end
      end
    end
  end

  assign w1      = move_q[0];
  assign a1      = move_q[1];
  assign s1      = move_q[2];
  assign d1      = move_q[3];
  assign w2      = move_q[4];
  assign a2      = move_q[5];
  assign s2      = move_q[6];
  assign d2      = move_q[7];
  assign pause   = shot_q[0];
  assign space   = shot_q[1];
  assign rst_req = shot_q[2];
  assign boom1   = shot_q[3];
  assign boom2   = shot_q[4];
  assign held    = held_q;

endmodule
